mult9_mac_sched: RTL and testbench

- Round-robin scheduler that shares one registered 8x9 signed multiplier among NUM_REQ requesters.
- Each requester streams (a, b) operand pairs and owns a private accumulator. On a pair flagged last, the block emits that requester's dot-product sum, tagged with its id.
- Sits between the conv/FC tap sequencers and the activation stage of the classifier datapath.

---
 rtl/mult9_pkg.sv | 17 +
 rtl/mult9_prod_reg.sv | 45 ++++
 rtl/mult9_mac_sched.sv | 146 ++++++++++++++
 tb/tb_mult9_mac_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult9_pkg.sv
// rtl/mult9_pkg.sv - shared widths and stage-1 payload type for the mult9 MAC scheduler
package mult9_pkg;

    localparam int A_W      = 8;
    localparam int B_W      = 9;
    localparam int P_W      = 17;
    // Widest requester id the block supports (NUM_REQ up to 8)
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                  valid;
        logic [ID_MAX_W-1:0]   id;
        logic                  last;
        logic signed [P_W-1:0] prod;
    } s1_t;

endpackage

// File: rtl/mult9_prod_reg.sv
// rtl/mult9_prod_reg.sv - registered signed 8x9 multiplier with load and hold
module mult9_prod_reg
    import mult9_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  hold_i,
    input  logic [A_W-1:0]        a_i,
    input  logic [B_W-1:0]        b_i,
    input  logic [ID_MAX_W-1:0]   id_i,
    input  logic                  last_i,
    output s1_t                   s1_o
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    s1_t                   s1_d;
    s1_t                   s1_q;

    always_comb begin
        a_ext = {{(P_W-A_W){a_i[A_W-1]}}, a_i};
        b_ext = {{(P_W-B_W){b_i[B_W-1]}}, b_i};
        s1_d  = s1_q;
        if (!hold_i) begin
            s1_d.valid = load_i;
            if (load_i) begin
                s1_d.id   = id_i;
                s1_d.last = last_i;
                s1_d.prod = a_ext * b_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign s1_o = s1_q;

endmodule

// File: rtl/mult9_mac_sched.sv
// rtl/mult9_mac_sched.sv - round-robin shared 8x9 MAC, per-requester accumulators; MULT9_MAC_SAT_EN selects saturation
module mult9_mac_sched
    import mult9_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ACC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*A_W-1:0]   req_a,
    input  logic [NUM_REQ*B_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_W-1:0]          out_id,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy
);

    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             stall;
    logic             accept;
    s1_t              s1;
    logic [ID_W-1:0]  s2_id;
    logic             s2_fire;
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] sum;
    logic             acc_nz;
    logic             id_hi_unused;
    logic [ACC_W-1:0] acc_q [NUM_REQ];
    logic             out_valid_q;
    logic [ID_W-1:0]  out_id_q;
    logic [ACC_W-1:0] out_data_q;

    function automatic logic [ID_W-1:0] wrap_id(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    assign stall = out_valid_q & ~out_ready;

    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_id(int'(rr_ptr_q) + k);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        if (found && !stall) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept   = found & ~stall;
    assign rr_ptr_d = accept ? wrap_id(int'(gnt_id) + 1) : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    mult9_prod_reg u_prod (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .hold_i (stall),
        .a_i    (req_a[int'(gnt_id)*A_W +: A_W]),
        .b_i    (req_b[int'(gnt_id)*B_W +: B_W]),
        .id_i   (ID_MAX_W'(gnt_id)),
        .last_i (req_last[gnt_id]),
        .s1_o   (s1)
    );

    assign s2_id        = s1.id[ID_W-1:0];
    assign s2_fire      = s1.valid & ~stall;
    assign id_hi_unused = ^s1.id;

    // One guard bit above the accumulator exposes signed overflow
    always_comb begin
        wide = {acc_q[s2_id][ACC_W-1], acc_q[s2_id]}
             + {{(ACC_W+1-P_W){s1.prod[P_W-1]}}, s1.prod};
`ifdef MULT9_MAC_SAT_EN
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = wide[ACC_W-1:0];
        end
`else
        sum = wide[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else if (s2_fire) begin
            acc_q[s2_id] <= s1.last ? '0 : sum;
        end
    end

    // A fresh result may replace one being handed off in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else if (s2_fire && s1.last) begin
            out_valid_q <= 1'b1;
            out_id_q    <= s2_id;
            out_data_q  <= sum;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        acc_nz = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_q[i] != '0) begin
                acc_nz = 1'b1;
            end
        end
    end

    assign busy      = rst & (s1.valid | acc_nz);
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mult9_mac_sched.sv
// tb/tb_mult9_mac_sched.sv - scoreboard bench for mult9_mac_sched
module tb_mult9_mac_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ACC_W   = 18;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*8-1:0]    req_a = '0;
    logic [NUM_REQ*9-1:0]    req_b = '0;
    logic [NUM_REQ-1:0]      req_last = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [ID_W-1:0]         out_id;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    mult9_mac_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; bit last; } pair_t;
    typedef struct { int id; longint data; } res_t;

    pair_t  src_q [NUM_REQ][$];
    res_t   sb_q[$];
    int     checks = 0;
    int     failures = 0;
    longint m_acc [NUM_REQ];
    int     m_ptr = 0;
    bit     m_s1_v = 0;
    bit     m_s1_last = 0;
    bit     m_out_v = 0;
    int     gcnt [NUM_REQ];
    longint last_out = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint m_add(input longint acc, input longint p);
        longint s;
        longint lim;
        s   = acc + p;
        lim = longint'(1) << (ACC_W-1);
`ifdef MULT9_MAC_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
`else
        s = s & ((lim << 1) - 1);
        if (s >= lim) s = s - (lim << 1);
`endif
        return s;
    endfunction

    task automatic push_pair(input int r, input int a, input int b, input bit last);
        pair_t p;
        p.a = a; p.b = b; p.last = last;
        src_q[r].push_back(p);
    endtask

    task automatic drive_heads();
        pair_t p;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                p = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_a[i*8 +: 8]    = 8'(p.a);
                req_b[i*9 +: 9]    = 9'(p.b);
                req_last[i]        = p.last;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [NUM_REQ-1:0] exp_rdy;
        bit    stall;
        bit    m_busy;
        int    gid;
        pair_t p;
        res_t  r;
        exp_rdy = '0;
        gid = -1;
        if (!rst) begin
            check_eq("busy_in_reset", busy, 0);
            m_ptr = 0; m_s1_v = 0; m_s1_last = 0; m_out_v = 0;
            sb_q.delete();
            for (int i = 0; i < NUM_REQ; i++) m_acc[i] = 0;
            return;
        end
        stall = m_out_v && !out_ready;
        if (!stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (gid < 0 && req_valid[c]) gid = c;
            end
        end
        if (gid >= 0) exp_rdy[gid] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("out_valid", out_valid, m_out_v);
        m_busy = m_s1_v;
        for (int i = 0; i < NUM_REQ; i++) if (m_acc[i] != 0) m_busy = 1;
        check_eq("busy", busy, m_busy);
        if (m_out_v) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", sb_q.size() > 0, 1);
            end else begin
                check_eq("out_id", out_id, sb_q[0].id);
                check_eq("out_data", out_data, sb_q[0].data);
                if (out_ready) begin
                    last_out = out_data;
                    void'(sb_q.pop_front());
                end
            end
        end
        if (!stall) begin
            m_out_v   = m_s1_v && m_s1_last;
            m_s1_v    = (gid >= 0);
            m_s1_last = (gid >= 0) ? src_q[gid][0].last : 1'b0;
        end
        if (gid >= 0) begin
            p = src_q[gid].pop_front();
            gcnt[gid]++;
            m_acc[gid] = m_add(m_acc[gid], longint'(p.a) * longint'(p.b));
            if (p.last) begin
                r.id = gid; r.data = m_acc[gid];
                sb_q.push_back(r);
                m_acc[gid] = 0;
            end
            m_ptr = (gid + 1) % NUM_REQ;
        end
    endtask

    task automatic step();
        drive_heads();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic bit tb_idle();
        bit idle;
        idle = !m_s1_v && !m_out_v && (sb_q.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) idle = 0;
        return idle;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!tb_idle() && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_done", tb_idle(), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NUM_REQ; i++) begin m_acc[i] = 0; gcnt[i] = 0; end
        @(posedge clk); #1;
        step();
        step();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_id", out_id, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req_ready", req_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;

        push_pair(0, 3, 5, 0);
        push_pair(0, -2, 7, 0);
        push_pair(0, 127, -256, 1);
        drain(50);
        check_eq("single_result", last_out, -32511);

        for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < NUM_REQ; i++)
                push_pair(i, $urandom_range(0, 255) - 128, $urandom_range(0, 511) - 256, j == 3);
        drain(80);
        for (int i = 0; i < NUM_REQ; i++) check_eq("fair_count", gcnt[i], 4);

        for (int j = 0; j < 4; j++)
            for (int i = 0; i < NUM_REQ; i++)
                if (i != 1 || j < 2)
                    push_pair(i, $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10, (i == 1) ? (j == 1) : (j == 3));
        drain(80);

        for (int j = 0; j < 3; j++) begin
            push_pair(1, 1, 1, j == 2);
            push_pair(2, 2, -3, j == 2);
        end
        drain(50);
        check_eq("interleave_last", last_out, -18);

        push_pair(0, 5, 5, 1);
        for (int j = 0; j < 3; j++) begin
            push_pair(1, j + 1, 2, j == 2);
            push_pair(2, -j, 3, j == 2);
        end
        n = 0;
        while (!m_out_v && n < 20) begin step(); n++; end
        check_eq("bp_pending", m_out_v, 1);
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        drain(60);

        push_pair(3, 7, 9, 0);
        push_pair(3, -3, 5, 0);
        step();
        step();
        check_eq("rst_mid_accepted", src_q[3].size(), 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        push_pair(3, 4, 4, 1);
        drain(50);
        check_eq("rst_mid_result", last_out, 16);

        for (int j = 0; j < 5; j++) push_pair(2, -128, -256, j == 4);
        drain(50);
`ifdef MULT9_MAC_SAT_EN
        check_eq("ovf_result", last_out, 131071);
`else
        check_eq("ovf_result", last_out, -98304);
`endif

        for (int t = 0; t < 12; t++) begin
            int r;
            int len;
            r   = $urandom_range(0, NUM_REQ - 1);
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
                push_pair(r, $urandom_range(0, 255) - 128, $urandom_range(0, 511) - 256, j == len - 1);
        end
        for (int t = 0; t < 150; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
